// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: fetch/decode/execute/mem/writeback/branch sequencing,
// datapath strobes, memory-timeout handling and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 5,
  parameter int ALU_FN_W    = 3,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_z,
  input  logic                flag_n,
  input  logic                stall,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src_branch,
  output logic                reg_write,
  output logic                is_move,
  output logic                is_imm,
  output logic                flags_write,
  output logic                dm_req,
  output logic                dm_write_enable,
  output logic [ALU_FN_W-1:0] alu_function,
  output logic [1:0]          writeData_select,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    retired_count,
  output logic                illegal_op,
  output logic                mem_fault
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_BRANCH    = 3'd5
  } state_t;

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_MOV  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_LI   = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_CMP  = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_JZ   = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_JNZ  = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_JG   = OPCODE_W'(15);
  localparam logic [OPCODE_W-1:0] OP_JL   = OPCODE_W'(16);
  localparam logic [OPCODE_W-1:0] OP_JUMP = OPCODE_W'(17);

  state_t            state_q, state_n;
  logic [WAIT_W-1:0] wait_q, wait_n;
  logic              run_q;
  logic              retire;

  function automatic logic [2:0] alu_code(input logic [OPCODE_W-1:0] op);
    case (op)
      OPCODE_W'(2), OP_SUBI, OP_CMP: alu_code = 3'd1;
      OPCODE_W'(3):                  alu_code = 3'd3;
      OPCODE_W'(4):                  alu_code = 3'd2;
      OPCODE_W'(5):                  alu_code = 3'd4;
      default:                       alu_code = 3'd0;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [OPCODE_W-1:0] op,
                                        input logic z, input logic n);
    case (op)
      OP_JZ:   branch_taken = z;
      OP_JNZ:  branch_taken = !z;
      OP_JG:   branch_taken = !z && !n;
      OP_JL:   branch_taken = n;
      OP_JUMP: branch_taken = 1'b1;
      default: branch_taken = 1'b0;
    endcase
  endfunction

  logic op_illegal, op_branch, op_mem, op_flags;
  assign op_illegal = (opcode > OP_JUMP);
  assign op_branch  = (opcode >= OP_JZ) && !op_illegal;
  assign op_mem     = (opcode == OP_LW) || (opcode == OP_SW);
  assign op_flags   = ((opcode >= OPCODE_W'(1)) && (opcode <= OP_MOV)) ||
                      ((opcode >= OP_ADDI) && (opcode <= OP_CMP));

  assign state = state_q;

  // run_q keeps every strobe low in the first cycle after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_FETCH;
      wait_q        <= '0;
      run_q         <= 1'b0;
      retired_count <= '0;
    end else begin
      state_q <= state_n;
      wait_q  <= wait_n;
      run_q   <= 1'b1;
      if (retire) retired_count <= retired_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_n          = state_q;
    wait_n           = wait_q;
    retire           = 1'b0;
    imem_req         = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src_branch    = 1'b0;
    reg_write        = 1'b0;
    is_move          = 1'b0;
    is_imm           = 1'b0;
    flags_write      = 1'b0;
    dm_req           = 1'b0;
    dm_write_enable  = 1'b0;
    alu_function     = '0;
    writeData_select = 2'b00;
    illegal_op       = 1'b0;
    mem_fault        = 1'b0;
    if (run_q && !stall) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_n  = S_DECODE;
          end
        end
        S_DECODE: begin
          if (op_illegal) begin
            illegal_op = 1'b1;
            state_n    = S_FETCH;
          end else if (opcode == OP_NOP) begin
            retire  = 1'b1;
            state_n = S_FETCH;
          end else if (op_branch) begin
            state_n = S_BRANCH;
          end else if (op_mem) begin
            wait_n  = '0;
            state_n = S_MEM;
          end else begin
            state_n = S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          alu_function = ALU_FN_W'(alu_code(opcode));
          is_imm       = (opcode == OP_ADDI) || (opcode == OP_SUBI);
          flags_write  = op_flags;
          if (opcode == OP_CMP) begin
            retire  = 1'b1;
            state_n = S_FETCH;
          end else begin
            state_n = S_WRITEBACK;
          end
        end
        S_MEM: begin
          // Timeout is judged on the registered count so mem_fault never depends on dmem_ready
          if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
            mem_fault = 1'b1;
            wait_n    = '0;
            state_n   = S_FETCH;
          end else begin
            dm_req          = 1'b1;
            dm_write_enable = (opcode == OP_SW);
            if (dmem_ready) begin
              wait_n = '0;
              if (opcode == OP_SW) begin
                retire  = 1'b1;
                state_n = S_FETCH;
              end else begin
                state_n = S_WRITEBACK;
              end
            end else begin
              wait_n = wait_q + WAIT_W'(1);
            end
          end
        end
        S_WRITEBACK: begin
          reg_write = 1'b1;
          if (opcode == OP_MOV) begin
            writeData_select = 2'b01;
            is_move          = 1'b1;
          end else if (opcode == OP_LW) begin
            writeData_select = 2'b10;
          end else if (opcode == OP_LI) begin
            writeData_select = 2'b11;
          end
          retire  = 1'b1;
          state_n = S_FETCH;
        end
        S_BRANCH: begin
          pc_src_branch = 1'b1;
          pc_write      = branch_taken(opcode, flag_z, flag_n);
          retire        = 1'b1;
          state_n       = S_FETCH;
        end
        default: state_n = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit; a second instance
// with a 4-bit counter shares the stimulus to observe counter wrap.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] opcode = '0;
  logic       flag_z = 1'b0, flag_n = 1'b0, stall = 1'b0;
  logic       imem_ready = 1'b0, dmem_ready = 1'b0;

  logic        imem_req, ir_write, pc_write, pc_src_branch, reg_write, is_move, is_imm;
  logic        flags_write, dm_req, dm_write_enable, illegal_op, mem_fault;
  logic [2:0]  alu_function, state;
  logic [1:0]  wds;
  logic [15:0] retired_count;

  logic        imem_req_4, ir_write_4, pc_write_4, pc_src_branch_4, reg_write_4, is_move_4, is_imm_4;
  logic        flags_write_4, dm_req_4, dm_write_enable_4, illegal_op_4, mem_fault_4;
  logic [2:0]  alu_function_4, state_4;
  logic [1:0]  wds_4;
  logic [3:0]  retired_count_4;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cnt = '0;

  wire [11:0] strobes = {imem_req, ir_write, pc_write, pc_src_branch, reg_write, is_move,
                         is_imm, flags_write, dm_req, dm_write_enable, illegal_op, mem_fault};

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .flag_z(flag_z), .flag_n(flag_n),
    .stall(stall), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src_branch(pc_src_branch),
    .reg_write(reg_write), .is_move(is_move), .is_imm(is_imm), .flags_write(flags_write),
    .dm_req(dm_req), .dm_write_enable(dm_write_enable), .alu_function(alu_function),
    .writeData_select(wds), .state(state), .retired_count(retired_count),
    .illegal_op(illegal_op), .mem_fault(mem_fault)
  );

  multicycle_control_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .flag_z(flag_z), .flag_n(flag_n),
    .stall(stall), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req_4), .ir_write(ir_write_4), .pc_write(pc_write_4),
    .pc_src_branch(pc_src_branch_4), .reg_write(reg_write_4), .is_move(is_move_4),
    .is_imm(is_imm_4), .flags_write(flags_write_4), .dm_req(dm_req_4),
    .dm_write_enable(dm_write_enable_4), .alu_function(alu_function_4),
    .writeData_select(wds_4), .state(state_4), .retired_count(retired_count_4),
    .illegal_op(illegal_op_4), .mem_fault(mem_fault_4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // From FETCH: deliver the instruction and leave the FSM in DECODE
  task automatic run_fetch(input logic [4:0] op);
    opcode = op;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (state !== 3'd0 || retired_count !== 16'd0 || strobes !== 12'd0 ||
        alu_function !== 3'd0 || wds !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d cnt=%0d strobes=%b alu=%0d sel=%0d, expected all 0",
               state, retired_count, strobes, alu_function, wds);
    end
    reset_n = 1'b1;
    tick();
    n_tests++;
    if (imem_req !== 1'b1 || state !== 3'd0 || ir_write !== 1'b0) begin
      n_fail++;
      $display("FAIL first_fetch: imem_req=%b state=%0d ir_write=%b, expected 1/0/0",
               imem_req, state, ir_write);
    end
    tick();
    n_tests++;
    if (state !== 3'd0 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_wait: state=%0d imem_req=%b, expected 0/1", state, imem_req);
    end
    exp_cnt = '0;
  endtask

  task automatic test_add;
    opcode = 5'h01;
    imem_ready = 1'b1;
    #1;
    n_tests++;
    if (state !== 3'd0 || ir_write !== 1'b1 || pc_write !== 1'b1) begin
      n_fail++;
      $display("FAIL add_fetch: state=%0d ir_write=%b pc_write=%b, expected 0/1/1",
               state, ir_write, pc_write);
    end
    tick();
    imem_ready = 1'b0;
    #1;
    n_tests++;
    if (state !== 3'd1 || strobes !== 12'd0) begin
      n_fail++;
      $display("FAIL add_decode: state=%0d strobes=%b, expected 1/0", state, strobes);
    end
    tick();
    n_tests++;
    if (state !== 3'd2 || flags_write !== 1'b1 || alu_function !== 3'd0 || reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL add_execute: state=%0d flags_write=%b alu=%0d reg_write=%b, expected 2/1/0/0",
               state, flags_write, alu_function, reg_write);
    end
    tick();
    n_tests++;
    if (state !== 3'd4 || reg_write !== 1'b1 || wds !== 2'b00) begin
      n_fail++;
      $display("FAIL add_writeback: state=%0d reg_write=%b sel=%0d, expected 4/1/0",
               state, reg_write, wds);
    end
    tick();
    exp_cnt++;
    n_tests++;
    if (state !== 3'd0 || retired_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL add_retire: state=%0d cnt=%0d, expected 0/%0d", state, retired_count, exp_cnt);
    end
  endtask

  task automatic test_alu_ops;
    logic [4:0] ops  [9] = '{5'h1, 5'h2, 5'h3, 5'h4, 5'h5, 5'h6, 5'h9, 5'hA, 5'hB};
    logic [2:0] fns  [9] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd0, 3'd0, 3'd0, 3'd1};
    logic       flg  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       imm  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] sel  [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd0, 2'd0};
    logic       mov  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      run_fetch(ops[i]);
      tick();
      n_tests++;
      if (state !== 3'd2 || alu_function !== fns[i] || flags_write !== flg[i] || is_imm !== imm[i]) begin
        n_fail++;
        $display("FAIL alu_exec op=%h: state=%0d alu=%0d flags=%b imm=%b, expected 2/%0d/%b/%b",
                 ops[i], state, alu_function, flags_write, is_imm, fns[i], flg[i], imm[i]);
      end
      tick();
      n_tests++;
      if (state !== 3'd4 || reg_write !== 1'b1 || wds !== sel[i] || is_move !== mov[i]) begin
        n_fail++;
        $display("FAIL alu_wb op=%h: state=%0d reg_write=%b sel=%0d move=%b, expected 4/1/%0d/%b",
                 ops[i], state, reg_write, wds, is_move, sel[i], mov[i]);
      end
      tick();
      exp_cnt++;
      n_tests++;
      if (state !== 3'd0 || retired_count !== exp_cnt) begin
        n_fail++;
        $display("FAIL alu_retire op=%h: state=%0d cnt=%0d, expected 0/%0d",
                 ops[i], state, retired_count, exp_cnt);
      end
    end
  endtask

  task automatic test_cmp;
    run_fetch(5'hC);
    tick();
    n_tests++;
    if (state !== 3'd2 || alu_function !== 3'd1 || flags_write !== 1'b1) begin
      n_fail++;
      $display("FAIL cmp_exec: state=%0d alu=%0d flags=%b, expected 2/1/1", state, alu_function, flags_write);
    end
    tick();
    exp_cnt++;
    n_tests++;
    if (state !== 3'd0 || retired_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL cmp_retire: state=%0d cnt=%0d, expected 0/%0d", state, retired_count, exp_cnt);
    end
  endtask

  task automatic test_branches;
    logic [4:0] ops [8] = '{5'hF, 5'hF, 5'hD, 5'hD, 5'hE, 5'h10, 5'h10, 5'h11};
    logic       z   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       n   [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       tk  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      flag_z = z[i];
      flag_n = n[i];
      run_fetch(ops[i]);
      tick();
      n_tests++;
      if (state !== 3'd5 || pc_src_branch !== 1'b1 || pc_write !== tk[i]) begin
        n_fail++;
        $display("FAIL branch op=%h z=%b n=%b: state=%0d src=%b pc_write=%b, expected 5/1/%b",
                 ops[i], z[i], n[i], state, pc_src_branch, pc_write, tk[i]);
      end
      tick();
      exp_cnt++;
      n_tests++;
      if (state !== 3'd0 || retired_count !== exp_cnt) begin
        n_fail++;
        $display("FAIL branch_retire op=%h: state=%0d cnt=%0d, expected 0/%0d",
                 ops[i], state, retired_count, exp_cnt);
      end
    end
    flag_z = 1'b0;
    flag_n = 1'b0;
  endtask

  task automatic test_lw;
    int errs = 0;
    run_fetch(5'h7);
    tick();
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      #1;
      if (state !== 3'd3 || dm_req !== 1'b1 || dm_write_enable !== 1'b0) errs++;
      tick();
    end
    dmem_ready = 1'b0;
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL lw_mem: %0d bad MEM cycles, expected 0", errs);
    end
    n_tests++;
    if (state !== 3'd4 || reg_write !== 1'b1 || wds !== 2'b10) begin
      n_fail++;
      $display("FAIL lw_wb: state=%0d reg_write=%b sel=%0d, expected 4/1/2", state, reg_write, wds);
    end
    tick();
    exp_cnt++;
    n_tests++;
    if (state !== 3'd0 || retired_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL lw_retire: state=%0d cnt=%0d, expected 0/%0d", state, retired_count, exp_cnt);
    end
  endtask

  task automatic test_sw_timeout;
    int errs = 0;
    run_fetch(5'h8);
    tick();
    for (int i = 0; i < 15; i++) begin
      #1;
      if (state !== 3'd3 || dm_req !== 1'b1 || dm_write_enable !== 1'b1 || mem_fault !== 1'b0) errs++;
      tick();
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL sw_wait: %0d bad wait cycles, expected 0", errs);
    end
    n_tests++;
    if (state !== 3'd3 || mem_fault !== 1'b1 || dm_write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_fault: state=%0d mem_fault=%b dm_we=%b, expected 3/1/0",
               state, mem_fault, dm_write_enable);
    end
    tick();
    n_tests++;
    if (state !== 3'd0 || retired_count !== exp_cnt || mem_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_abort: state=%0d cnt=%0d mem_fault=%b, expected 0/%0d/0",
               state, retired_count, mem_fault, exp_cnt);
    end
  endtask

  task automatic test_illegal;
    run_fetch(5'h1F);
    n_tests++;
    if (state !== 3'd1 || illegal_op !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_decode: state=%0d illegal_op=%b, expected 1/1", state, illegal_op);
    end
    tick();
    n_tests++;
    if (state !== 3'd0 || illegal_op !== 1'b0 || retired_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL illegal_return: state=%0d illegal_op=%b cnt=%0d, expected 0/0/%0d",
               state, illegal_op, retired_count, exp_cnt);
    end
  endtask

  task automatic test_stall;
    int errs = 0;
    run_fetch(5'h2);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (state !== 3'd2 || flags_write !== 1'b0 || retired_count !== exp_cnt) errs++;
      tick();
    end
    stall = 1'b0;
    #1;
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL stall_hold: %0d bad stalled cycles, expected 0", errs);
    end
    n_tests++;
    if (state !== 3'd2 || flags_write !== 1'b1 || alu_function !== 3'd1) begin
      n_fail++;
      $display("FAIL stall_release: state=%0d flags=%b alu=%0d, expected 2/1/1",
               state, flags_write, alu_function);
    end
    tick();
    tick();
    exp_cnt++;
    n_tests++;
    if (state !== 3'd0 || retired_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL stall_retire: state=%0d cnt=%0d, expected 0/%0d", state, retired_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_mem;
    int errs = 0;
    run_fetch(5'h7);
    tick();
    #1;
    n_tests++;
    if (state !== 3'd3) begin
      n_fail++;
      $display("FAIL rst_mem_enter: state=%0d, expected 3", state);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (state !== 3'd0 || strobes !== 12'd0 || retired_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_mem_async: state=%0d strobes=%b cnt=%0d, expected 0/0/0",
               state, strobes, retired_count);
    end
    dmem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (reg_write !== 1'b0 || dm_write_enable !== 1'b0 || state !== 3'd0) errs++;
    end
    dmem_ready = 1'b0;
    reset_n = 1'b1;
    tick();
    exp_cnt = '0;
    n_tests++;
    if (errs != 0 || state !== 3'd0 || imem_req !== 1'b1 || reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mem_after: errs=%0d state=%0d imem_req=%b reg_write=%b, expected 0/0/1/0",
               errs, state, imem_req, reg_write);
    end
  endtask

  task automatic test_wrap;
    int errs = 0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      run_fetch(5'h0);
      tick();
      if (state !== 3'd0) errs++;
    end
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL nop_latency: %0d nops not back in FETCH after 2 cycles, expected 0", errs);
    end
    n_tests++;
    if (retired_count_4 !== 4'd1 || retired_count !== 16'd17) begin
      n_fail++;
      $display("FAIL count_wrap: cnt4=%0d cnt16=%0d, expected 1/17", retired_count_4, retired_count);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_cmp();
    test_branches();
    test_lw();
    test_sw_timeout();
    test_illegal();
    test_stall();
    test_reset_mid_mem();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
